// File: rtl/tinychip_pkg.sv
// Shared widths, payload types and fetch FSM encoding for the tinychip front end.
package tinychip_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 9;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP_INSTR = 9'b000000000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Instruction word paired with the address it was fetched from.
    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_word_t;

endpackage : tinychip_pkg

// File: rtl/fetch_unit_if.sv
// Decoder/memory-facing signal bundle of the fetch stage.
interface fetch_unit_if;
    import tinychip_pkg::*;

    logic   start;
    logic   stall;
    logic   branch_taken;
    addr_t  branch_target;
    logic   halt;
    instr_t imem_instr;
    addr_t  imem_addr;
    instr_t instr_out;
    addr_t  instr_pc;
    logic   instr_valid;
    logic   busy;
    logic   done;

    // Environment side: decoder controls and memory read data.
    modport master (
        output start, stall, branch_taken, branch_target, halt, imem_instr,
        input  imem_addr, instr_out, instr_pc, instr_valid, busy, done
    );

    // Fetch unit side.
    modport slave (
        input  start, stall, branch_taken, branch_target, halt, imem_instr,
        output imem_addr, instr_out, instr_pc, instr_valid, busy, done
    );

endinterface : fetch_unit_if

// File: rtl/fetch_skid_reg.sv
// Single-entry hold buffer that parks the presented instruction while the decoder stalls.
module fetch_skid_reg
    import tinychip_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        release_i,
    input  fetch_word_t word_i,
    output fetch_word_t word_o,
    output logic        valid_o
);

    fetch_word_t hold_q, hold_d;
    logic        hold_valid_q, hold_valid_d;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (load_i) begin
            hold_d       = word_i;
            hold_valid_d = 1'b1;
        end else if (release_i) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign word_o  = hold_q;
    assign valid_o = hold_valid_q;

endmodule : fetch_skid_reg

// File: rtl/fetch_unit.sv
// Program counter and fetch control in front of a memory with one cycle of registered read latency.
module fetch_unit
    import tinychip_pkg::*;
#(
    parameter addr_t START_ADDR = ADDR_W'(0)
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);

    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    addr_t        req_pc_q, req_pc_d;
    logic         req_valid_q, req_valid_d;

    logic         skid_load, skid_release, hold_valid;
    fetch_word_t  skid_in, hold_word;
    logic         instr_valid_c;

    assign instr_valid_c = hold_valid | req_valid_q;
    assign skid_in       = '{instr: bus.imem_instr, pc: req_pc_q};

    fetch_skid_reg u_skid (
        .clk       (clk),
        .reset     (reset),
        .load_i    (skid_load),
        .release_i (skid_release),
        .word_i    (skid_in),
        .word_o    (hold_word),
        .valid_o   (hold_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= START_ADDR;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
        end
    end

    // Next state: req_valid tracks whether the address now at the memory was a real fetch.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        req_valid_d  = req_valid_q;
        skid_load    = 1'b0;
        skid_release = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d     = RUN;
                    pc_d        = START_ADDR;
                    req_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (bus.stall) begin
                    // Park the live word once; pc is held so the memory refetches behind it.
                    skid_load = ~hold_valid & req_valid_q;
                end else begin
                    skid_release = hold_valid;
                    if (instr_valid_c && bus.halt) begin
                        state_d     = HALT;
                        req_valid_d = 1'b0;
                    end else if (instr_valid_c && bus.branch_taken) begin
                        pc_d        = bus.branch_target;
                        req_valid_d = 1'b0;
                    end else begin
                        pc_d        = pc_q + ADDR_W'(1);
                        req_pc_d    = pc_q;
                        req_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                pc_d        = START_ADDR;
                req_valid_d = 1'b0;
            end
        endcase
    end

    // Outputs: skid contents take precedence over the live memory word.
    always_comb begin
        bus.imem_addr   = pc_q;
        bus.busy        = (state_q == RUN);
        bus.done        = (state_q == HALT);
        bus.instr_valid = instr_valid_c;
        bus.instr_out   = NOP_INSTR;
        bus.instr_pc    = '0;
        if (hold_valid) begin
            bus.instr_out = hold_word.instr;
            bus.instr_pc  = hold_word.pc;
        end else if (req_valid_q) begin
            bus.instr_out = bus.imem_instr;
            bus.instr_pc  = req_pc_q;
        end
    end

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Fetch unit paired with a behavioural instruction memory (mem[i] = i + 9'h100).
module tb_fetch_unit;

    logic clk;
    logic reset;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0] mem [256];

    always @(posedge clk) bus.imem_instr <= mem[bus.imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0 idle, 1 run, 2 halt; m_pc is the next address the decoder must see,
    // m_wait counts unstalled run cycles left before it becomes visible.
    int m_st   = 0;
    int m_pc   = 0;
    int m_wait = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic m_reset();
        m_st   = 0;
        m_pc   = 0;
        m_wait = 0;
    endtask

    task automatic check_outputs();
        logic ev;
        int   ea;
        ev = (m_st == 1) && (m_wait == 0);
        if (m_st == 0)              ea = 0;
        else if (ev || m_st == 2)   ea = (m_pc + 1) % 256;
        else                        ea = m_pc;
        chk("instr_valid", 16'(bus.instr_valid), 16'(ev));
        chk("busy", 16'(bus.busy), 16'(m_st == 1));
        chk("done", 16'(bus.done), 16'(m_st == 2));
        chk("imem_addr", 16'(bus.imem_addr), 16'(ea));
        if (ev) begin
            chk("instr_pc", 16'(bus.instr_pc), 16'(m_pc));
            chk("instr_out", 16'(bus.instr_out), 16'(m_pc + 'h100));
        end else begin
            chk("instr_out_idle", 16'(bus.instr_out), 16'h0);
            chk("instr_pc_idle", 16'(bus.instr_pc), 16'h0);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance model and clock.
    task automatic cyc(input logic st, input logic sl, input logic br,
                       input logic [7:0] tgt, input logic hl);
        bus.start         = st;
        bus.stall         = sl;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.halt          = hl;
        #1;
        check_outputs();
        case (m_st)
            0, 2: begin
                if (st) begin
                    m_st   = 1;
                    m_pc   = 0;
                    m_wait = 1;
                end
            end
            default: begin
                if (!sl) begin
                    if (m_wait > 0) m_wait--;
                    else if (hl) m_st = 2;
                    else if (br) begin
                        m_pc   = int'(tgt);
                        m_wait = 1;
                    end else m_pc = (m_pc + 1) % 256;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Reset asserted between clock edges must clear outputs without waiting for the clock.
    task automatic async_rst();
        #2;
        reset = 1'b1;
        #1;
        m_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b0;
    endtask

    initial begin
        logic       st, sl, br, hl;
        logic [7:0] tgt;

        for (int i = 0; i < 256; i++) mem[i] = 9'(i + 'h100);
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 8'h00;
        bus.halt          = 1'b0;
        m_reset();

        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        reset = 1'b0;

        // Start: first valid instruction two cycles after the pulse.
        idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_cyc();
        chk("start_first_out", 16'(bus.instr_out), 16'h100);
        chk("start_first_pc", 16'(bus.instr_pc), 16'h0);
        idle_cyc();
        chk("start_second_out", 16'(bus.instr_out), 16'h101);
        idle_cyc();
        idle_cyc();

        // Stall on 9'h103 for three cycles, then release.
        chk("pre_stall_out", 16'(bus.instr_out), 16'h103);
        repeat (3) cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("stall_hold_out", 16'(bus.instr_out), 16'h103);
        chk("stall_hold_pc", 16'(bus.instr_pc), 16'h3);
        chk("stall_addr_frozen", 16'(bus.imem_addr), 16'h4);
        idle_cyc();
        chk("post_stall_out", 16'(bus.instr_out), 16'h104);
        idle_cyc();
        chk("post_stall_next", 16'(bus.instr_out), 16'h105);

        // Branch to 8'h40: one squashed bubble.
        cyc(1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
        chk("branch_squash", 16'(bus.instr_valid), 16'h0);
        idle_cyc();
        chk("branch_target_out", 16'(bus.instr_out), 16'h140);
        chk("branch_target_pc", 16'(bus.instr_pc), 16'h40);
        idle_cyc();
        idle_cyc();

        // Halt beats a simultaneous branch; restart from address 0.
        cyc(1'b0, 1'b0, 1'b1, 8'h80, 1'b1);
        chk("halt_done", 16'(bus.done), 16'h1);
        chk("halt_busy", 16'(bus.busy), 16'h0);
        repeat (3) cyc(1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle_cyc();
        chk("restart_out", 16'(bus.instr_out), 16'h100);
        idle_cyc();

        // Wrap past 8'hFF, with a stalled branch that must be ignored.
        cyc(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0);
        idle_cyc();
        chk("wrap_fe", 16'(bus.instr_out), 16'h1FE);
        idle_cyc();
        chk("wrap_ff", 16'(bus.instr_out), 16'h1FF);
        cyc(1'b0, 1'b1, 1'b1, 8'h20, 1'b0);
        idle_cyc();
        chk("wrap_00_out", 16'(bus.instr_out), 16'h100);
        chk("wrap_00_pc", 16'(bus.instr_pc), 16'h0);
        idle_cyc();

        // Async reset mid-run, then mid-stall.
        async_rst();
        repeat (3) idle_cyc();
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (3) idle_cyc();
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        async_rst();
        chk("rst_stall_valid", 16'(bus.instr_valid), 16'h0);
        idle_cyc();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_rst();
            end else begin
                st  = ($urandom_range(0, 7) == 0);
                sl  = ($urandom_range(0, 9) < 3);
                br  = ($urandom_range(0, 9) == 0);
                tgt = 8'($urandom_range(0, 255));
                hl  = ($urandom_range(0, 39) == 0);
                cyc(st, sl, br, tgt, hl);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
